// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT transpose-buffer control path.
// The 8x8 block is addressed as {row, col}, with three bits in each field.
package idct_pkg;

  localparam int ADDR_W = 6;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t BLK_LAST = 6'd63;

  // Swap the row and column fields so that a row-major count walks the block column by column.
  function automatic addr_t transpose_addr(input addr_t idx);
    return {idx[2:0], idx[5:3]};
  endfunction

  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/transpose_ctrl_if.sv
// Handshake and bank-control bundle between the transpose controller and its surroundings.
// The master modport is the controller side. The slave modport is the row pass, the column pass and the banks.
interface transpose_ctrl_if;
  import idct_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic [1:0] w_en;
  addr_t      w_addr;
  logic [1:0] r_en;
  addr_t      r_addr;
  logic       d_sel;
  logic [1:0] full;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, out_last, w_en, w_addr, r_en, r_addr, d_sel, full
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, out_last, w_en, w_addr, r_en, r_addr, d_sel, full
  );

endinterface

// File: rtl/tc_bank_ptr.sv
// Bank pointer plus 6-bit element counter. The write side and the read side each use one instance.
// The wrap output pulses on the advance that consumes element 63; on that advance the bank toggles.
module tc_bank_ptr
  import idct_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  adv,
  output logic  bank,
  output addr_t cnt,
  output logic  wrap
);

  assign wrap = adv && (cnt == BLK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= 1'b0;
      cnt  <= '0;
    end else if (clr) begin
      bank <= 1'b0;
      cnt  <= '0;
    end else if (adv) begin
      cnt <= cnt + 1'b1;
      if (wrap) begin
        bank <= ~bank;
      end
    end
  end

endmodule

// File: rtl/transpose_ctrl.sv
// Ping-pong sequencer for the IDCT transpose buffer. Samples are written into the banks row-major
// and read back column-major. This block drives only enables, addresses, the mux select and handshakes.
module transpose_ctrl
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  transpose_ctrl_if.master  bus
);

  logic       wb;
  logic       rb;
  addr_t      wcnt;
  addr_t      rcnt;
  logic       wr_wrap;
  logic       rd_wrap;
  logic       wr_fire;
  logic       rd_go;
  logic [1:0] full_q;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;
  logic       out_valid_q;
  logic       out_last_q;
  logic       d_sel_q;

  assign wr_fire = bus.in_valid && !full_q[wb];
  // A new read may launch only when the output register is empty or is being consumed this cycle.
  assign rd_go   = full_q[rb] && (!out_valid_q || bus.out_ready);

  tc_bank_ptr u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (wr_fire),
    .bank  (wb),
    .cnt   (wcnt),
    .wrap  (wr_wrap)
  );

  tc_bank_ptr u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (rd_go),
    .bank  (rb),
    .cnt   (rcnt),
    .wrap  (rd_wrap)
  );

  // A set and a clear always target different banks, so the order of OR and AND-NOT does not matter.
  assign set_mask = wr_wrap ? bank_onehot(wb) : 2'b00;
  assign clr_mask = rd_wrap ? bank_onehot(rb) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 2'b00;
    end else if (clr) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q | set_mask) & ~clr_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      d_sel_q     <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      d_sel_q     <= 1'b0;
    end else if (rd_go) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (rcnt == BLK_LAST);
      d_sel_q     <= rb;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // When a bank is stalled its r_en stays low, so the bank keeps presenting the held d_out.
  assign bus.in_ready  = !full_q[wb];
  assign bus.w_en      = wr_fire ? bank_onehot(wb) : 2'b00;
  assign bus.w_addr    = wr_fire ? wcnt : '0;
  assign bus.r_en      = rd_go ? bank_onehot(rb) : 2'b00;
  assign bus.r_addr    = rd_go ? transpose_addr(rcnt) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.d_sel     = d_sel_q;
  assign bus.full      = full_q;

  full_set_clear_disjoint: assert property (
    @(posedge clk) disable iff (!rst_n) (set_mask & clr_mask) == 2'b00
  );

  write_blocked_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.w_en[0] && full_q[0]) && !(bus.w_en[1] && full_q[1])
  );

endmodule

// File: tb/tb_transpose_ctrl.sv
// Scoreboard bench for transpose_ctrl: it models two 1-cycle-latency banks and checks the
// transposed output stream, the write/read addressing, backpressure, clr and asynchronous reset.
module tb_transpose_ctrl;
  import idct_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        bank;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;
  logic [15:0] in_data;

  transpose_ctrl_if bus ();

  transpose_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  logic [15:0] mem [2][64];
  logic [15:0] dout [2];

  exp_t        sb_q [$];
  logic [6:0]  rd_log [$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int phase_outs = 0;
  int first_out_cyc = 0;
  int last_out_cyc = 0;
  int last_wr_cyc = 0;
  int stalls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank models: synchronous write, registered read that holds while r_en is low.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bus.w_en[b]) mem[b][bus.w_addr] <= in_data;
      if (bus.r_en[b]) dout[b] <= mem[b][bus.r_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output and logs every bank read.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_data", 32'(dout[bus.d_sel]), 32'(e.data));
        check("out_last", 32'(bus.out_last), 32'(e.last));
        check("out_bank", 32'(bus.d_sel), 32'(e.bank));
      end
      if (phase_outs == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      phase_outs++;
    end
    if (rst_n && bus.r_en != 2'b00) rd_log.push_back({bus.r_en[1], bus.r_addr});
  end

  task automatic push_block(input int blk, input logic bank);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.data = 16'(blk * 64 + (i % 8) * 8 + i / 8);
      e.last = (i == 63);
      e.bank = bank;
      sb_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_w_en"},      32'(bus.w_en), 32'd0);
    check({tag, "_r_en"},      32'(bus.r_en), 32'd0);
    check({tag, "_w_addr"},    32'(bus.w_addr), 32'd0);
    check({tag, "_r_addr"},    32'(bus.r_addr), 32'd0);
    check({tag, "_full"},      32'(bus.full), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"},  32'(bus.out_last), 32'd0);
    check({tag, "_d_sel"},     32'(bus.d_sel), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    in_data = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    sb_q.delete();
    rd_log.delete();
    phase_outs = 0;
    stalls = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offers one sample and waits, within a bound, for it to be accepted.
  task automatic apply_stimulus(input logic [15:0] data, input logic [1:0] exp_wen, input logic [5:0] exp_addr);
    int tries;
    tries = 0;
    bus.in_valid = 1'b1;
    in_data = data;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        check("w_en", 32'(bus.w_en), 32'(exp_wen));
        check("w_addr", 32'(bus.w_addr), 32'(exp_addr));
        last_wr_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      stalls++;
      tries++;
      if (tries > 300) begin
        check("write_timeout", 32'(tries), 32'd0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic write_block(input int blk, input logic bank, input int first);
    for (int j = first; j < 64; j++) begin
      apply_stimulus(16'(blk * 64 + j), bank_onehot(bank), 6'(j));
    end
  endtask

  task automatic check_output(input int budget);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int nreads;
    int rd63_cyc;
    int rise_cyc;
    int bank0_reads;

    // Single block: addressing, latency and transposed read order.
    do_reset();
    bus.out_ready = 1'b1;
    push_block(0, 1'b0);
    write_block(0, 1'b0, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_full", 32'(bus.full), 32'b01);
    @(posedge clk); #1;
    check_output(200);
    check("t1_latency", 32'(first_out_cyc - last_wr_cyc), 32'd2);
    check("t1_out_count", 32'(phase_outs), 32'd64);
    check("t1_reads", 32'(rd_log.size()), 32'd64);
    for (int i = 0; i < 64 && i < rd_log.size(); i++) begin
      check("t1_r_addr", 32'(rd_log[i]), 32'((i % 8) * 8 + i / 8));
    end

    // Four blocks streamed back to back.
    do_reset();
    bus.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) push_block(b + 1, 1'(b % 2));
    for (int b = 0; b < 4; b++) write_block(b + 1, 1'(b % 2), 0);
    bus.in_valid = 1'b0;
    check_output(400);
    check("t2_stalls", 32'(stalls), 32'd0);
    check("t2_out_count", 32'(phase_outs), 32'd256);
    check("t2_gap_free", 32'(last_out_cyc - first_out_cyc), 32'd255);

    // Fill both banks with the column pass stalled.
    do_reset();
    bus.out_ready = 1'b0;
    push_block(0, 1'b0);
    push_block(1, 1'b1);
    push_block(2, 1'b0);
    write_block(0, 1'b0, 0);
    write_block(1, 1'b1, 0);
    bus.in_valid = 1'b1;
    in_data = 16'(2 * 64);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t3_in_ready", 32'(bus.in_ready), 32'd0);
      check("t3_w_en", 32'(bus.w_en), 32'd0);
      check("t3_full", 32'(bus.full), 32'b11);
      check("t3_out_valid", 32'(bus.out_valid), 32'd1);
      check("t3_r_en", 32'(bus.r_en), 32'd0);
      @(posedge clk); #1;
    end
    check("t3_reads", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() > 0) check("t3_first_r_addr", 32'(rd_log[0]), 32'd0);

    // Release out_ready at full backpressure and time the in_ready recovery.
    bus.out_ready = 1'b1;
    rd63_cyc = -100;
    rise_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.r_en == 2'b01 && bus.r_addr == 6'd63) rd63_cyc = cyc;
      if (bus.in_ready) begin
        rise_cyc = cyc;
        check("t4_w_en", 32'(bus.w_en), 32'b01);
        check("t4_w_addr", 32'(bus.w_addr), 32'd0);
        check("t4_full", 32'(bus.full), 32'b10);
        break;
      end
      @(posedge clk); #1;
    end
    check("t4_in_ready_rise", 32'(rise_cyc - rd63_cyc), 32'd1);
    bank0_reads = 0;
    foreach (rd_log[i]) if (!rd_log[i][6]) bank0_reads++;
    check("t4_bank0_reads", 32'(bank0_reads), 32'd64);
    @(posedge clk); #1;
    write_block(2, 1'b0, 1);
    bus.in_valid = 1'b0;
    check_output(300);

    // clr mid-block after 30 writes and 10 reads.
    do_reset();
    bus.out_ready = 1'b1;
    push_block(3, 1'b0);
    write_block(3, 1'b0, 0);
    nreads = 0;
    for (int j = 0; j < 30; j++) begin
      bus.in_valid = 1'b1;
      in_data = 16'(4 * 64 + j);
      bus.out_ready = (nreads < 10);
      @(negedge clk);
      if (bus.r_en != 2'b00) nreads++;
      @(posedge clk); #1;
    end
    check("t5_reads", 32'(nreads), 32'd10);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_reset_outputs("clr");
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push_block(5, 1'b0);
    write_block(5, 1'b0, 0);
    bus.in_valid = 1'b0;
    check_output(200);

    // Asynchronous reset while output is valid.
    do_reset();
    bus.out_ready = 1'b1;
    push_block(6, 1'b0);
    write_block(6, 1'b0, 0);
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6_out_valid_pre", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_full", 32'(bus.full), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_r_en", 32'(bus.r_en), 32'd0);
    check("t6_out_last", 32'(bus.out_last), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
